// File: rtl/mvau_pkg.sv
// ---------------------------------------------------------------------------
// mvau_pkg
// Shared definitions for the MVAU weight-memory address sequencer.
//   - wctrl_state_t : two-state controller encoding (IDLE / RUN)
//   - cnt_bw        : width helper for a fold counter that counts 0..n-1
//   - depth_ok      : elaboration check that the memory depth matches SF*NF
//   - addr_bw_ok    : elaboration check that the address width covers the depth
// ---------------------------------------------------------------------------
package mvau_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wctrl_state_t;

    // A counter over 0..n-1 needs at least one bit even when n is 1.
    function automatic int unsigned cnt_bw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // The address walk relies on one full SF*NF sweep per pixel, so the
    // memory must hold exactly that many words.
    function automatic bit depth_ok(input int unsigned sf,
                                    input int unsigned nf,
                                    input int unsigned depth);
        return depth == sf * nf;
    endfunction

    function automatic bit addr_bw_ok(input int unsigned depth,
                                      input int unsigned bw);
        return (64'd1 << bw) >= 64'(depth);
    endfunction

endpackage

// File: rtl/mvau_wmem_ctrl_fold_cnt.sv
// ---------------------------------------------------------------------------
// mvau_fold_cnt
// Parameterised wrap counter used for the synapse, neuron and repetition
// folds. Counts 0..MAX-1 on inc_i and wraps back to 0.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clr_i   : synchronous clear, takes priority over inc_i
//   inc_i   : advance by one this cycle
//   last_o  : count is currently MAX-1
//   wrap_o  : count wraps on this cycle (inc_i while last_o)
// ---------------------------------------------------------------------------
module mvau_fold_cnt #(
    parameter int unsigned MAX = 2,
    parameter int unsigned BW  = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o,
    output logic wrap_o
);

    localparam logic [BW-1:0] LAST = BW'(MAX - 1);

    logic [BW-1:0] cnt_q;
    logic [BW-1:0] cnt_d;

    assign last_o = (cnt_q == LAST);
    assign wrap_o = inc_i & last_o;

    // Wrap to zero on the last value so the chained counter above sees
    // exactly one wrap pulse per full sweep.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mvau_wmem_ctrl.sv
// ---------------------------------------------------------------------------
// mvau_wmem_ctrl
// Address sequencer for one MVAU PE weight memory (1-cycle registered read).
// Walks SF words per neuron row, NF rows per pixel, NUM_REPS pixels per frame,
// and tags each returned word with valid / row-last / pixel-last markers that
// line up with the memory read latency.
// Ports:
//   aclk           : clock, rising edge
//   aresetn        : asynchronous active-low reset
//   start          : frame start pulse, accepted only when idle
//   adv            : one weight word is consumed this cycle
//   wmem_addr      : registered read address to the weight memory
//   wt_vld         : memory output word is valid this cycle
//   sf_last        : valid word is the last of its neuron row
//   nf_last        : valid word is the last word of the pixel
//   busy           : frame in progress
//   frame_done     : one-cycle pulse with the final word of the frame
//   perf_stall_cnt : (MVAU_WMEM_CTRL_PERF_EN only) RUN cycles without adv
// Optional feature macro: MVAU_WMEM_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module mvau_wmem_ctrl
    import mvau_pkg::*;
#(
    parameter int unsigned SF           = 2,
    parameter int unsigned NF           = 2,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned NUM_REPS     = 3,
    parameter int unsigned REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    adv,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    wt_vld,
    output logic                    sf_last,
    output logic                    nf_last,
    output logic                    busy,
`ifdef MVAU_WMEM_CTRL_PERF_EN
    output logic [31:0]             perf_stall_cnt,
`endif
    output logic                    frame_done
);

    if (!depth_ok(SF, NF, WMEM_DEPTH)) begin : g_bad_depth
        $error("mvau_wmem_ctrl: WMEM_DEPTH must equal SF*NF");
    end
    if (!addr_bw_ok(WMEM_DEPTH, WMEM_ADDR_BW)) begin : g_bad_addr_bw
        $error("mvau_wmem_ctrl: WMEM_ADDR_BW too narrow for WMEM_DEPTH");
    end
    if (NUM_REPS < 1) begin : g_bad_reps
        $error("mvau_wmem_ctrl: NUM_REPS must be at least 1");
    end

    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    wctrl_state_t            state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic                    vld_q, sf_last_q, nf_last_q, done_q;

    logic start_acc;
    logic beat;
    logic sf_is_last, sf_wrap;
    logic nf_is_last, nf_wrap;
    logic rep_is_last, rep_wrap;

    assign start_acc = (state_q == IDLE) && start;
    assign beat      = (state_q == RUN) && adv;

    mvau_fold_cnt #(.MAX(SF), .BW(cnt_bw(SF))) u_sf_cnt (
        .clk_i (aclk),
        .rst_ni(aresetn),
        .clr_i (start_acc),
        .inc_i (beat),
        .last_o(sf_is_last),
        .wrap_o(sf_wrap)
    );

    mvau_fold_cnt #(.MAX(NF), .BW(cnt_bw(NF))) u_nf_cnt (
        .clk_i (aclk),
        .rst_ni(aresetn),
        .clr_i (start_acc),
        .inc_i (sf_wrap),
        .last_o(nf_is_last),
        .wrap_o(nf_wrap)
    );

    mvau_fold_cnt #(.MAX(NUM_REPS), .BW(REP_BW)) u_rep_cnt (
        .clk_i (aclk),
        .rst_ni(aresetn),
        .clr_i (start_acc),
        .inc_i (nf_wrap),
        .last_o(rep_is_last),
        .wrap_o(rep_wrap)
    );

    // The repetition counter wrapping means the final word of the frame was
    // just issued, so the controller drops back to IDLE on that beat.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                end
                if (rep_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Markers are sampled on the adv beat and registered once so they arrive
    // together with the word the memory read on that beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            vld_q     <= 1'b0;
            sf_last_q <= 1'b0;
            nf_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            vld_q     <= beat;
            sf_last_q <= beat & sf_is_last;
            nf_last_q <= beat & sf_is_last & nf_is_last;
            done_q    <= nf_wrap & rep_is_last;
        end
    end

    assign wmem_addr  = addr_q;
    assign wt_vld     = vld_q;
    assign sf_last    = sf_last_q;
    assign nf_last    = nf_last_q;
    assign frame_done = done_q;
    // busy drops as the FSM re-enters IDLE, which is the cycle frame_done is high.
    assign busy       = (state_q == RUN);

`ifdef MVAU_WMEM_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Stall cycles are RUN cycles without a beat; the count saturates and is
    // left untouched while idle so it can be read after the frame.
    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if ((state_q == RUN) && !adv && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mvau_wmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mvau_wmem_ctrl
// Self-checking bench for mvau_wmem_ctrl. A main instance (SF=2, NF=2,
// NUM_REPS=2) and a degenerate instance (SF=1, NF=3, NUM_REPS=1) share one
// clock. A behavioural memory register mimics the weight memory so that the
// word returned with each wt_vld can be checked against its position in the
// frame.
// ---------------------------------------------------------------------------
module tb_mvau_wmem_ctrl;

    localparam int MSF    = 2;
    localparam int MNF    = 2;
    localparam int MD     = MSF * MNF;
    localparam int MREPS  = 2;
    localparam int MTOTAL = MD * MREPS;

    typedef struct packed {
        logic [3:0] addr;
        logic       vld;
        logic       sfl;
        logic       nfl;
        logic       done;
        logic       busy;
    } outs_t;

    typedef struct {
        bit    s;
        bit    a;
        outs_t e;
    } vec_t;

    logic       clk;
    logic       aresetn;
    logic       start, adv;
    logic [3:0] wmem_addr;
    logic       wt_vld, sf_last, nf_last, busy, frame_done;
    logic       start2, adv2;
    logic [1:0] wmem_addr2;
    logic       wt_vld2, sf_last2, nf_last2, busy2, frame_done2;
`ifdef MVAU_WMEM_CTRL_PERF_EN
    logic [31:0] perf, perf2;
`endif

    logic [3:0] memA;

    int testsRun    = 0;
    int testsFailed = 0;
    int vldSeen     = 0;

    bit mRun  = 0;
    int mWord = 0;

    mvau_wmem_ctrl #(
        .SF(MSF), .NF(MNF), .WMEM_DEPTH(MD), .WMEM_ADDR_BW(4),
        .NUM_REPS(MREPS), .REP_BW(16)
    ) u_dut (
        .aclk(clk), .aresetn(aresetn), .start(start), .adv(adv),
        .wmem_addr(wmem_addr), .wt_vld(wt_vld), .sf_last(sf_last),
        .nf_last(nf_last), .busy(busy),
`ifdef MVAU_WMEM_CTRL_PERF_EN
        .perf_stall_cnt(perf),
`endif
        .frame_done(frame_done)
    );

    mvau_wmem_ctrl #(
        .SF(1), .NF(3), .WMEM_DEPTH(3), .WMEM_ADDR_BW(2),
        .NUM_REPS(1), .REP_BW(4)
    ) u_deg (
        .aclk(clk), .aresetn(aresetn), .start(start2), .adv(adv2),
        .wmem_addr(wmem_addr2), .wt_vld(wt_vld2), .sf_last(sf_last2),
        .nf_last(nf_last2), .busy(busy2),
`ifdef MVAU_WMEM_CTRL_PERF_EN
        .perf_stall_cnt(perf2),
`endif
        .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural weight memory: registered read of whatever address is presented.
    always @(posedge clk) memA <= wmem_addr;

    function automatic outs_t sampleMain();
        outs_t o;
        o = '{addr: wmem_addr, vld: wt_vld, sfl: sf_last, nfl: nf_last,
              done: frame_done, busy: busy};
        return o;
    endfunction

    function automatic outs_t sampleDeg();
        outs_t o;
        o = '{addr: {2'b00, wmem_addr2}, vld: wt_vld2, sfl: sf_last2,
              nfl: nf_last2, done: frame_done2, busy: busy2};
        return o;
    endfunction

    function automatic vec_t mk(input bit s, input bit a, input int addr,
                                input bit v, input bit sl, input bit nl,
                                input bit d, input bit b);
        vec_t r;
        r.s = s;
        r.a = a;
        r.e = '{addr: 4'(addr), vld: v, sfl: sl, nfl: nl, done: d, busy: b};
        return r;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input int dut, input bit s, input bit a);
        if (dut == 0) begin
            start = s;
            adv   = a;
        end else begin
            start2 = s;
            adv2   = a;
        end
        @(posedge clk);
        #1;
    endtask

    // Frame model: word k of a frame is address k mod depth; row-last when
    // k mod SF is SF-1, pixel-last when k mod depth is depth-1, frame ends at
    // k = depth*reps-1.
    task automatic modelStep(input bit s, input bit a, output outs_t e,
                             output int memExp);
        e      = '0;
        memExp = 0;
        if (!mRun) begin
            if (s) begin
                mRun  = 1;
                mWord = 0;
            end
        end else if (a) begin
            e.vld  = 1'b1;
            e.sfl  = (mWord % MSF) == MSF - 1;
            e.nfl  = (mWord % MD) == MD - 1;
            e.done = (mWord == MTOTAL - 1);
            memExp = mWord % MD;
            mWord++;
            if (mWord == MTOTAL) begin
                mRun  = 0;
                mWord = 0;
            end
        end
        e.addr = 4'(mWord % MD);
        e.busy = mRun;
    endtask

    task automatic runCycle(input bit s, input bit a, input string nm);
        outs_t e;
        int    memExp;
        modelStep(s, a, e, memExp);
        applyStimulus(0, s, a);
        checkOutput(nm, 32'(sampleMain()), 32'(e));
        if (e.vld) checkOutput({nm, "_word"}, 32'(memA), 32'(memExp));
        if (wt_vld) vldSeen++;
    endtask

    vec_t mainTbl[10];
    vec_t degTbl[4];
    bit   stallPat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    initial begin
        // Continuous run of the main instance, one row per clock.
        mainTbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 1);
        mainTbl[1] = mk(0, 1, 1, 1, 0, 0, 0, 1);
        mainTbl[2] = mk(0, 1, 2, 1, 1, 0, 0, 1);
        mainTbl[3] = mk(0, 1, 3, 1, 0, 0, 0, 1);
        mainTbl[4] = mk(0, 1, 0, 1, 1, 1, 0, 1);
        mainTbl[5] = mk(0, 1, 1, 1, 0, 0, 0, 1);
        mainTbl[6] = mk(0, 1, 2, 1, 1, 0, 0, 1);
        mainTbl[7] = mk(0, 1, 3, 1, 0, 0, 0, 1);
        mainTbl[8] = mk(0, 1, 0, 1, 1, 1, 1, 0);
        mainTbl[9] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        // Degenerate instance: SF=1, NF=3, single pass.
        degTbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1);
        degTbl[1]  = mk(0, 1, 1, 1, 1, 0, 0, 1);
        degTbl[2]  = mk(0, 1, 2, 1, 1, 0, 0, 1);
        degTbl[3]  = mk(0, 1, 0, 1, 1, 1, 1, 0);

        aresetn = 1'b0;
        start = 0; adv = 0; start2 = 0; adv2 = 0;
        #3;
        checkOutput("reset_main", 32'(sampleMain()), 32'd0);
        checkOutput("reset_deg", 32'(sampleDeg()), 32'd0);
        #4 aresetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, mainTbl[i].s, mainTbl[i].a);
            checkOutput($sformatf("cont_%0d", i), 32'(sampleMain()), 32'(mainTbl[i].e));
            if (mainTbl[i].e.vld)
                checkOutput($sformatf("cont_word_%0d", i), 32'(memA), 32'((i - 1) % MD));
        end

        vldSeen = 0;
        runCycle(1, 0, "stall_start");
        for (int i = 0; i < 12; i++) runCycle(0, stallPat[i], $sformatf("stall_%0d", i));
        runCycle(0, 0, "stall_tail");
        checkOutput("stall_words", 32'(vldSeen), 32'd8);

        vldSeen = 0;
        runCycle(1, 0, "ign_start");
        runCycle(0, 1, "ign_w0");
        runCycle(0, 1, "ign_w1");
        runCycle(1, 1, "ign_w2_start");
        for (int i = 3; i < 7; i++) runCycle(0, 1, $sformatf("ign_w%0d", i));
        runCycle(1, 1, "ign_last_start");
        runCycle(0, 1, "ign_after0");
        runCycle(0, 1, "ign_after1");
        checkOutput("ign_words", 32'(vldSeen), 32'd8);

        runCycle(1, 0, "rst_start");
        for (int i = 0; i < 3; i++) runCycle(0, 1, $sformatf("rst_w%0d", i));
        #3 aresetn = 1'b0;
        #1;
        checkOutput("rst_async", 32'(sampleMain()), 32'd0);
        mRun  = 0;
        mWord = 0;
        @(posedge clk);
        #1;
        checkOutput("rst_held", 32'(sampleMain()), 32'd0);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) runCycle(0, 1, $sformatf("rst_noStart%0d", i));
        runCycle(1, 0, "rst_restart");
        for (int i = 0; i < MTOTAL; i++) runCycle(0, 1, $sformatf("rst_frame%0d", i));

        for (int i = 0; i < 400; i++)
            runCycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                     $sformatf("rand_%0d", i));
        for (int i = 0; i < MTOTAL && mRun; i++) runCycle(0, 1, $sformatf("drain_%0d", i));

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, degTbl[i].s, degTbl[i].a);
            checkOutput($sformatf("deg_%0d", i), 32'(sampleDeg()), 32'(degTbl[i].e));
        end
        applyStimulus(1, 0, 0);
        checkOutput("deg_idle", 32'(sampleDeg()), 32'd0);

`ifdef MVAU_WMEM_CTRL_PERF_EN
        begin
            bit perfPat[13] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1};
            runCycle(1, 0, "perf_start");
            for (int i = 0; i < 13; i++) runCycle(0, perfPat[i], $sformatf("perf_%0d", i));
            checkOutput("perf_at_done", perf, 32'd5);
            runCycle(0, 0, "perf_idle");
            checkOutput("perf_hold", perf, 32'd5);
            runCycle(1, 0, "perf_restart");
            checkOutput("perf_clear", perf, 32'd0);
            for (int i = 0; i < MTOTAL; i++) runCycle(0, 1, $sformatf("perf_fin%0d", i));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
